// File: rtl/player_motion_if.sv
// rtl/player_motion_if.sv - frame sync, button and sprite output bundle of one player's motion engine
interface player_motion_if;
  logic       vsync_n;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [3:0] state;
  logic       frame_tick;

  modport master (
    output vsync_n, btn_left, btn_right, btn_jump,
    input  pos_x, pos_y, state, frame_tick
  );

  modport slave (
    input  vsync_n, btn_left, btn_right, btn_jump,
    output pos_x, pos_y, state, frame_tick
  );
endinterface

// File: rtl/player_motion.sv
// rtl/player_motion.sv - per-player walk/jump physics, stepped once per video frame on vsync fall
module player_motion #(
  parameter logic        [9:0] START_X    = 10'd100,
  parameter logic        [9:0] GROUND_Y   = 10'd380,
  parameter logic        [9:0] MIN_X      = 10'd0,
  parameter logic        [9:0] MAX_X      = 10'd576,
  parameter logic        [9:0] WALK_SPEED = 10'd4,
  parameter logic signed [7:0] JUMP_VEL   = 8'sd16,
  parameter logic signed [7:0] GRAVITY    = 8'sd1
) (
  input logic            clk,
  input logic            rst,
  player_motion_if.slave bus
);

  typedef enum logic [3:0] {
    ST_STAND = 4'd0,
    ST_JUMP  = 4'd1,
    ST_WALK  = 4'd2,
    ST_LAND  = 4'd3
  } state_t;

  localparam logic signed [11:0] GROUND_S = {2'b00, GROUND_Y};
  localparam logic signed [7:0]  MAX_FALL = -JUMP_VEL;

  logic left_meta, left_s;
  logic right_meta, right_s;
  logic jump_meta, jump_s;
  logic vsync_q;
  logic frame_tick;

  state_t            cur_state, nxt_state;
  logic        [9:0] x_r, x_nxt, x_step;
  logic        [9:0] y_r, y_nxt;
  logic signed [7:0] vel_r, vel_nxt, vel_dec, vel_fall;
  logic signed [11:0] y_sum;
  logic              jump_prev;
  logic              jump_req, go_left, go_right;

  // Button synchronizers and vsync falling-edge detect run every clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_meta  <= 1'b0;
      left_s     <= 1'b0;
      right_meta <= 1'b0;
      right_s    <= 1'b0;
      jump_meta  <= 1'b0;
      jump_s     <= 1'b0;
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      left_meta  <= bus.btn_left;
      left_s     <= left_meta;
      right_meta <= bus.btn_right;
      right_s    <= right_meta;
      jump_meta  <= bus.btn_jump;
      jump_s     <= jump_meta;
      vsync_q    <= bus.vsync_n;
      frame_tick <= vsync_q & ~bus.vsync_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_STAND;
      x_r       <= START_X;
      y_r       <= GROUND_Y;
      vel_r     <= 8'sd0;
      jump_prev <= 1'b0;
    end else if (frame_tick) begin
      cur_state <= nxt_state;
      x_r       <= x_nxt;
      y_r       <= y_nxt;
      vel_r     <= vel_nxt;
      jump_prev <= jump_s;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    x_nxt     = x_r;
    y_nxt     = y_r;
    vel_nxt   = vel_r;

    jump_req = jump_s & ~jump_prev;
    go_left  = left_s & ~right_s;
    go_right = right_s & ~left_s;

    // Clamp before stepping so the 10-bit position can never wrap
    x_step = x_r;
    if (go_left)
      x_step = (x_r < MIN_X + WALK_SPEED) ? MIN_X : x_r - WALK_SPEED;
    else if (go_right)
      x_step = (x_r > MAX_X - WALK_SPEED) ? MAX_X : x_r + WALK_SPEED;

    y_sum    = $signed({2'b00, y_r}) - $signed({{4{vel_r[7]}}, vel_r});
    vel_dec  = vel_r - GRAVITY;
    vel_fall = (vel_dec < MAX_FALL) ? MAX_FALL : vel_dec;

    case (cur_state)
      ST_STAND, ST_WALK: begin
        x_nxt = x_step;
        if (jump_req) begin
          nxt_state = ST_JUMP;
          vel_nxt   = JUMP_VEL;
        end else if (go_left || go_right) begin
          nxt_state = ST_WALK;
        end else begin
          nxt_state = ST_STAND;
        end
      end
      ST_JUMP: begin
        x_nxt = x_step;
        if (y_sum >= GROUND_S) begin
          y_nxt     = GROUND_Y;
          vel_nxt   = 8'sd0;
          nxt_state = ST_LAND;
        end else if (y_sum < 12'sd0) begin
          y_nxt   = 10'd0;
          vel_nxt = 8'sd0;
        end else begin
          y_nxt   = y_sum[9:0];
          vel_nxt = vel_fall;
        end
      end
      ST_LAND: nxt_state = ST_STAND;
      default: nxt_state = ST_STAND;
    endcase
  end

  assign bus.pos_x      = x_r;
  assign bus.pos_y      = y_r;
  assign bus.state      = cur_state;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - randomized frame-level bench against a behavioural walk/jump model
module tb_player_motion;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  // Reference model state: 0=stand 1=jump 2=walk 3=land
  int mx = 100, my = 380, mst = 0, mvel = 0;
  bit mjprev = 1'b0;

  player_motion_if bus ();

  player_motion dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 100; my = 380; mst = 0; mvel = 0; mjprev = 1'b0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    bit jreq;
    int yn;
    jreq   = j && !mjprev;
    mjprev = j;
    if (mst != 3) begin
      if (l && !r)      mx = (mx - 4 < 0)   ? 0   : mx - 4;
      else if (r && !l) mx = (mx + 4 > 576) ? 576 : mx + 4;
    end
    case (mst)
      0, 2: begin
        if (jreq) begin mst = 1; mvel = 16; end
        else mst = (l != r) ? 2 : 0;
      end
      1: begin
        yn = my - mvel;
        if (yn >= 380) begin my = 380; mvel = 0; mst = 3; end
        else if (yn < 0) begin my = 0; mvel = 0; end
        else begin my = yn; mvel = (mvel - 1 < -16) ? -16 : mvel - 1; end
      end
      default: mst = 0;
    endcase
  endtask

  task automatic run_frame(input bit l, input bit r, input bit j);
    int ticks;
    int hold;
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_jump  = j;
    repeat (4) @(negedge clk);
    check("hold_x", bus.pos_x, mx);
    check("hold_state", bus.state, mst);
    bus.vsync_n = 1'b0;
    ticks = 0;
    hold  = $urandom_range(3, 20);
    repeat (hold) begin
      @(negedge clk);
      ticks += int'(bus.frame_tick);
    end
    bus.vsync_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ticks += int'(bus.frame_tick);
    end
    model_tick(l, r, j);
    check("tick_count", ticks, 1);
    check("pos_x", bus.pos_x, mx);
    check("pos_y", bus.pos_y, my);
    check("state", bus.state, mst);
  endtask

  initial begin
    bus.vsync_n   = 1'b1;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_jump  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", bus.pos_x, 100);
    check("rst_y", bus.pos_y, 380);
    check("rst_state", bus.state, 0);
    check("rst_tick", bus.frame_tick, 0);
    rst = 1'b1;

    repeat (3) run_frame(0, 0, 0);
    repeat (130) run_frame(0, 1, 0);
    run_frame(0, 0, 0);
    run_frame(0, 0, 1);
    repeat (40) run_frame(0, 0, 0);
    repeat (40) run_frame(0, 0, 1);
    run_frame(0, 0, 0);
    run_frame(0, 0, 1);
    repeat (36) run_frame($urandom_range(0, 1), $urandom_range(0, 1), 0);
    repeat (150) run_frame(1, 0, 0);
    repeat (3) run_frame(1, 1, 0);

    for (int i = 0; i < 250; i++)
      run_frame($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));

    // Reset while airborne, landing the async reset during a live frame_tick pulse
    repeat (3) run_frame(0, 0, 0);
    run_frame(0, 0, 1);
    repeat (5) run_frame(0, 0, 0);
    check("pre_rst_state", bus.state, mst);
    bus.vsync_n = 1'b0;
    @(negedge clk);
    check("pre_rst_tick", bus.frame_tick, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_x", bus.pos_x, mx);
    check("async_y", bus.pos_y, my);
    check("async_state", bus.state, mst);
    check("async_tick", bus.frame_tick, 0);
    bus.vsync_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20)
      run_frame($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
